ahb_input_stage_hold: RTL



---
 rtl/ahb_input_stage_hold.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ahb_input_stage_hold.sv
`default_nettype none
// ============================================================================
// Module  : ahb_input_stage_hold
// Brief   : Bus-matrix input port front end; presents master address phases
//           to the output stage, holding and stalling when not yet accepted.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_input_stage_hold #(
  parameter int ADDR_WIDTH = 32,
  parameter int MID_WIDTH  = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic [MID_WIDTH-1:0]  HMASTERS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  input  logic                  active_ip,
  input  logic                  readyout_ip,
  input  logic                  resp_ip,
  output logic                  sel_ip,
  output logic [ADDR_WIDTH-1:0] addr_ip,
  output logic [1:0]            trans_ip,
  output logic                  write_ip,
  output logic [2:0]            size_ip,
  output logic [2:0]            burst_ip,
  output logic [3:0]            prot_ip,
  output logic [MID_WIDTH-1:0]  master_ip,
  output logic                  mastlock_ip,
  output logic                  held_tran_ip
);

  typedef struct packed {
    logic                  sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic [MID_WIDTH-1:0]  master;
    logic                  mastlock;
  } ctrl_t;

  localparam logic [1:0] C_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] C_TRANS_SEQ    = 2'b11;

  ctrl_t hold_q, hold_d;
  ctrl_t live;
  logic  pend_q, pend_d;
  logic  data_ph_q, data_ph_d;
  logic  trans_valid;
  logic  grant;
  logic  launch;

  always_comb begin
    live.sel      = HSELS;
    live.addr     = HADDRS;
    live.trans    = HTRANSS;
    live.write    = HWRITES;
    live.size     = HSIZES;
    live.burst    = HBURSTS;
    live.prot     = HPROTS;
    live.master   = HMASTERS;
    live.mastlock = HMASTLOCKS;
  end

  always_comb begin
    trans_valid = HSELS & HTRANSS[1] & HREADYS;
    grant       = active_ip & readyout_ip;
    launch      = (trans_valid | pend_q) & grant;

    // The master is stalled while pend is set, so the captured transfer
    // must not be overwritten until it has been issued.
    hold_d = hold_q;
    if (trans_valid && !pend_q) begin
      hold_d = live;
    end

    pend_d = pend_q;
    if (pend_q && grant) begin
      pend_d = 1'b0;
    end else if (trans_valid && !grant) begin
      pend_d = 1'b1;
    end

    data_ph_d = data_ph_q;
    if (readyout_ip) begin
      data_ph_d = launch;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_q    <= '0;
      pend_q    <= 1'b0;
      data_ph_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      data_ph_q <= data_ph_d;
    end
  end

  always_comb begin
    sel_ip      = HSELS & HREADYS;
    addr_ip     = live.addr;
    trans_ip    = live.trans;
    write_ip    = live.write;
    size_ip     = live.size;
    burst_ip    = live.burst;
    prot_ip     = live.prot;
    master_ip   = live.master;
    mastlock_ip = live.mastlock;
    if (pend_q) begin
      sel_ip      = hold_q.sel;
      addr_ip     = hold_q.addr;
      // A held SEQ is re-issued as NONSEQ since the output stage may have
      // been switched to another master in the meantime.
      trans_ip    = (hold_q.trans == C_TRANS_SEQ) ? C_TRANS_NONSEQ : hold_q.trans;
      write_ip    = hold_q.write;
      size_ip     = hold_q.size;
      burst_ip    = hold_q.burst;
      prot_ip     = hold_q.prot;
      master_ip   = hold_q.master;
      mastlock_ip = hold_q.mastlock;
    end

    held_tran_ip = (pend_q | trans_valid) & ~HRESET;

    HREADYOUTS = 1'b1;
    if (pend_q) begin
      HREADYOUTS = 1'b0;
    end else if (data_ph_q) begin
      HREADYOUTS = readyout_ip;
    end

    HRESPS = data_ph_q ? resp_ip : 1'b0;
  end

  a_no_pend_in_data : assert property (@(posedge HCLK) disable iff (HRESET)
    !(pend_q && data_ph_q));

endmodule
`default_nettype wire
